uart_rx_oversampled: RTL and testbench

//  UART receiver; the receive end of the team's 8N1 UART link. Samples serial line rx, which is

---
 rtl/uart_rx_oversampled.sv | 176 +++++++++++++++++
 tb/tb_uart_rx_oversampled.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_oversampled.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_oversampled
// Purpose  : 8N1 UART receiver. The asynchronous serial line is brought into
//            the clk domain through a two-flop synchronizer. Start detection,
//            mid-bit sampling and stop checking all use BAUD_DIV clk cycles
//            per bit. Received bytes are offered on a valid/ready handshake.
//            Framing errors and overruns are reported as one-cycle pulses.
// Ports    : clk        in   system clock, all logic on posedge
//            reset      in   synchronous active-high reset
//            rx         in   serial line, idle high, asynchronous to clk
//            data_out   out  received byte, stable while data_valid is high
//            data_valid out  byte available, held until accepted
//            data_ready in   consumer accepts when data_valid && data_ready
//            busy       out  receiver is inside a frame (state != IDLE)
//            frame_err  out  one-cycle pulse, stop bit sampled low
//            overrun    out  one-cycle pulse, completed byte dropped
// Revision : 1.0  initial release
// ============================================================================
module uart_rx_oversampled #(
  parameter int BAUD_DIV = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] data_out,
  output logic       data_valid,
  input  logic       data_ready,
  output logic       busy,
  output logic       frame_err,
  output logic       overrun
);

  localparam int          HALF_DIV    = BAUD_DIV / 2;
  localparam logic [15:0] C_BAUD_LAST = 16'(BAUD_DIV - 1);
  localparam logic [15:0] C_HALF_LAST = 16'(HALF_DIV - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_STOP  = 3'd3;
  localparam logic [2:0] S_BREAK = 3'd4;

  logic        rx_meta_q, rx_s_q;
  logic [2:0]  state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  data_q, data_d;
  logic        valid_q, valid_d;
  logic        ferr_q, ferr_d;
  logic        ovr_q, ovr_d;

  logic w_baud_done;
  logic w_half_done;
  logic w_stop_sample;

  assign w_baud_done   = (cnt_q == C_BAUD_LAST);
  assign w_half_done   = (cnt_q == C_HALF_LAST);
  assign w_stop_sample = (state_q == S_STOP) && w_baud_done;

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      state_q   <= S_IDLE;
      cnt_q     <= 16'd0;
      idx_q     <= 3'd0;
      shift_q   <= 8'h00;
      data_q    <= 8'h00;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
      ovr_q     <= ovr_d;
    end
  end

  // Next-state and bit-timing logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    case (state_q)
      S_IDLE: begin
        if (!rx_s_q) begin
          state_d = S_START;
          cnt_d   = 16'd0;
        end
      end
      S_START: begin
        if (w_half_done) begin
          // Line back high at mid start bit: treat as a glitch.
          state_d = rx_s_q ? S_IDLE : S_DATA;
          cnt_d   = 16'd0;
          idx_d   = 3'd0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_DATA: begin
        if (w_baud_done) begin
          shift_d = {rx_s_q, shift_q[7:1]};
          cnt_d   = 16'd0;
          idx_d   = idx_q + 3'd1;
          if (idx_q == 3'd7) begin
            state_d = S_STOP;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_STOP: begin
        if (w_baud_done) begin
          cnt_d   = 16'd0;
          state_d = rx_s_q ? S_IDLE : S_BREAK;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_BREAK: begin
        // A held-low line stays here so it reports only one framing error.
        if (rx_s_q) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 16'd0;
        idx_d   = 3'd0;
      end
    endcase
  end

  // Delivery, handshake and status outputs
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    ferr_d  = 1'b0;
    ovr_d   = 1'b0;
    if (valid_q && data_ready) begin
      valid_d = 1'b0;
    end
    if (w_stop_sample && rx_s_q) begin
      // A byte accepted in this same cycle frees the slot for the new one.
      if (!valid_q || data_ready) begin
        data_d  = shift_q;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end
    if (w_stop_sample && !rx_s_q) begin
      ferr_d = 1'b1;
    end
    busy = (state_q != S_IDLE);
  end

  assign data_out   = data_q;
  assign data_valid = valid_q;
  assign frame_err  = ferr_q;
  assign overrun    = ovr_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_oversampled.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx_oversampled
// Purpose  : Self-checking bench for uart_rx_oversampled at BAUD_DIV=4 and
//            BAUD_DIV=16. Frames are generated bit by bit on the serial
//            line; a negedge monitor records accepted bytes and pulse counts.
// Revision : 1.0  initial release
// ============================================================================
module tb_uart_rx_oversampled;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rx4 = 1'b1, rx16 = 1'b1;
  logic       rdy4 = 1'b1, rdy16 = 1'b1;
  logic [7:0] dout4, dout16;
  logic       dv4, dv16, bz4, bz16, fe4, fe16, ov4, ov16;

  always #5 clk = ~clk;

  uart_rx_oversampled #(.BAUD_DIV(4)) u_dut4 (
    .clk(clk), .reset(reset), .rx(rx4), .data_out(dout4), .data_valid(dv4),
    .data_ready(rdy4), .busy(bz4), .frame_err(fe4), .overrun(ov4)
  );

  uart_rx_oversampled #(.BAUD_DIV(16)) u_dut16 (
    .clk(clk), .reset(reset), .rx(rx16), .data_out(dout16), .data_valid(dv16),
    .data_ready(rdy16), .busy(bz16), .frame_err(fe16), .overrun(ov16)
  );

  // Monitor: running counts only, tests compare deltas against a baseline.
  logic [7:0] got4[$];
  logic [7:0] got16[$];
  int vc4 = 0, fc4 = 0, oc4 = 0, bc4 = 0;
  int vc16 = 0, fc16 = 0, oc16 = 0;

  always @(negedge clk) begin
    if (dv4 && rdy4) got4.push_back(dout4);
    if (dv4) vc4++;
    if (fe4) fc4++;
    if (ov4) oc4++;
    if (bz4) bc4++;
    if (dv16 && rdy16) got16.push_back(dout16);
    if (dv16) vc16++;
    if (fe16) fc16++;
    if (ov16) oc16++;
  end

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive_bits(input int sel, input logic v, input int n);
    for (int i = 0; i < n; i++) begin
      if (sel == 0) rx4 = v; else rx16 = v;
      @(posedge clk);
      #1;
    end
  endtask

  // Leaves the line at the stop-bit level; caller restores idle after a bad stop.
  task automatic send_frame(input int sel, input logic [7:0] d, input logic stop_ok);
    int div;
    div = (sel == 0) ? 4 : 16;
    drive_bits(sel, 1'b0, div);
    for (int b = 0; b < 8; b++) drive_bits(sel, d[b], div);
    drive_bits(sel, stop_ok, div);
  endtask

  typedef struct {
    logic [7:0] data;
    logic       stop_ok;
    int         exp_valid;
    logic [7:0] exp_byte;
    int         exp_ferr;
  } vec_t;

  vec_t vecs[6];
  logic [7:0] exp_q[$];

  initial begin
    int base, v0, f0, o0, b0, exp_fe;
    logic [7:0] d;
    logic ok;

    vecs[0] = '{8'hA5, 1'b1, 1, 8'hA5, 0};
    vecs[1] = '{8'h00, 1'b1, 1, 8'h00, 0};
    vecs[2] = '{8'hFF, 1'b1, 1, 8'hFF, 0};
    vecs[3] = '{8'h01, 1'b1, 1, 8'h01, 0};
    vecs[4] = '{8'h55, 1'b0, 0, 8'h00, 1};
    vecs[5] = '{8'h80, 1'b1, 1, 8'h80, 0};

    // Reset state
    @(posedge clk); #1;
    cycles(3);
    @(negedge clk);
    check("rst_dout4", dout4, 8'h00);
    check("rst_valid4", dv4, 1'b0);
    check("rst_busy4", bz4, 1'b0);
    check("rst_ferr4", fe4, 1'b0);
    check("rst_ovr4", ov4, 1'b0);
    check("rst_valid16", dv16, 1'b0);
    @(posedge clk); #1;
    reset = 1'b0;
    cycles(4);

    // Table-driven single frames, consumer always ready
    for (int k = 0; k < 6; k++) begin
      base = got4.size(); v0 = vc4; f0 = fc4; o0 = oc4;
      send_frame(0, vecs[k].data, vecs[k].stop_ok);
      rx4 = 1'b1;
      cycles(8);
      check($sformatf("tbl%0d_nbytes", k), got4.size() - base, vecs[k].exp_valid);
      if (vecs[k].exp_valid > 0 && got4.size() > base)
        check($sformatf("tbl%0d_byte", k), got4[base], vecs[k].exp_byte);
      check($sformatf("tbl%0d_vcycles", k), vc4 - v0, vecs[k].exp_valid);
      check($sformatf("tbl%0d_ferr", k), fc4 - f0, vecs[k].exp_ferr);
      check($sformatf("tbl%0d_ovr", k), oc4 - o0, 0);
    end

    // Back-to-back frames without idle gap
    base = got4.size(); v0 = vc4;
    send_frame(0, 8'h00, 1'b1);
    send_frame(0, 8'hFF, 1'b1);
    send_frame(0, 8'h3C, 1'b1);
    cycles(8);
    check("b2b_nbytes", got4.size() - base, 3);
    if (got4.size() - base == 3) begin
      check("b2b_byte0", got4[base], 8'h00);
      check("b2b_byte1", got4[base+1], 8'hFF);
      check("b2b_byte2", got4[base+2], 8'h3C);
    end
    check("b2b_vcycles", vc4 - v0, 3);

    // One-cycle glitch: START lasts HALF_DIV cycles, then back to IDLE
    base = got4.size(); v0 = vc4; f0 = fc4; o0 = oc4; b0 = bc4;
    drive_bits(0, 1'b0, 1);
    rx4 = 1'b1;
    cycles(12);
    @(negedge clk);
    check("glitch_busy_cycles", bc4 - b0, 2);
    check("glitch_busy_now", bz4, 1'b0);
    check("glitch_valid", vc4 - v0, 0);
    check("glitch_ferr", fc4 - f0, 0);
    check("glitch_ovr", oc4 - o0, 0);

    // Bad stop then line held low: one framing error, busy until line high
    base = got4.size(); v0 = vc4; f0 = fc4;
    send_frame(0, 8'h55, 1'b0);
    drive_bits(0, 1'b0, 40);
    @(negedge clk);
    check("break_busy_low", bz4, 1'b1);
    check("break_ferr", fc4 - f0, 1);
    rx4 = 1'b1;
    cycles(6);
    @(negedge clk);
    check("break_busy_after", bz4, 1'b0);
    check("break_ferr_after", fc4 - f0, 1);
    check("break_valid", vc4 - v0, 0);

    // Overrun: consumer stalled across two frames
    @(posedge clk); #1;
    rdy4 = 1'b0;
    base = got4.size(); o0 = oc4;
    send_frame(0, 8'h12, 1'b1);
    send_frame(0, 8'h34, 1'b1);
    cycles(8);
    @(negedge clk);
    check("ovr_valid_held", dv4, 1'b1);
    check("ovr_dout_held", dout4, 8'h12);
    check("ovr_pulses", oc4 - o0, 1);
    @(posedge clk); #1;
    rdy4 = 1'b1;
    cycles(2);
    @(negedge clk);
    check("ovr_valid_drop", dv4, 1'b0);
    cycles(20);
    check("ovr_nbytes", got4.size() - base, 1);
    if (got4.size() > base) check("ovr_byte", got4[base], 8'h12);
    check("ovr_dout_kept", dout4, 8'h12);

    // Randomized frames against a frame-level reference model
    exp_q.delete();
    exp_fe = 0;
    base = got4.size(); v0 = vc4; f0 = fc4; o0 = oc4;
    for (int n = 0; n < 24; n++) begin
      d  = 8'($urandom_range(0, 255));
      ok = ($urandom_range(0, 4) != 0);
      if (ok) exp_q.push_back(d); else exp_fe++;
      send_frame(0, d, ok);
      rx4 = 1'b1;
      if (ok) drive_bits(0, 1'b1, $urandom_range(0, 5));
      else    drive_bits(0, 1'b1, 4 + $urandom_range(0, 3));
    end
    cycles(10);
    check("rand_nbytes", got4.size() - base, exp_q.size());
    if (got4.size() - base == exp_q.size())
      for (int i = 0; i < exp_q.size(); i++)
        check($sformatf("rand_byte%0d", i), got4[base+i], exp_q[i]);
    check("rand_vcycles", vc4 - v0, exp_q.size());
    check("rand_ferr", fc4 - f0, exp_fe);
    check("rand_ovr", oc4 - o0, 0);

    // Reset in the middle of a frame
    base = got4.size();
    drive_bits(0, 1'b0, 4);
    drive_bits(0, 1'b1, 4);
    drive_bits(0, 1'b0, 4);
    drive_bits(0, 1'b0, 2);
    reset = 1'b1;
    rx4 = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("mid_rst_busy", bz4, 1'b0);
    check("mid_rst_valid", dv4, 1'b0);
    check("mid_rst_dout", dout4, 8'h00);
    check("mid_rst_ferr", fe4, 1'b0);
    check("mid_rst_ovr", ov4, 1'b0);
    @(posedge clk); #1;
    reset = 1'b0;
    cycles(4);
    send_frame(0, 8'h7E, 1'b1);
    cycles(8);
    check("mid_rst_nbytes", got4.size() - base, 1);
    if (got4.size() > base) check("mid_rst_byte", got4[base], 8'h7E);

    // BAUD_DIV=16 instance
    base = got16.size(); v0 = vc16;
    send_frame(1, 8'hA5, 1'b1);
    cycles(20);
    check("d16_nbytes", got16.size() - base, 1);
    if (got16.size() > base) check("d16_byte", got16[base], 8'hA5);
    check("d16_vcycles", vc16 - v0, 1);
    check("d16_ferr", fc16, 0);
    check("d16_ovr", oc16, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
